sfx_sequencer: RTL and testbench

Sound-effect scheduler between GameLogic event pulses and AudioPlayer. It shares the single tone generator among four requesters by fixed priority, and plays each effect as a short note sequence from an internal table. It drives AudioPlayer with a half-period word, where 0 means silence. It runs entirely on the 40 MHz system clock.

---
 rtl/sfx_pkg.sv | 51 +++++
 rtl/sfx_note_rom.sv | 20 ++
 rtl/sfx_sequencer.sv | 156 +++++++++++++++
 tb/tb_sfx_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfx_pkg
// Purpose  : Shared effect IDs, note format, FSM encoding and note table
//            for the sound-effect sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sfx_pkg;

    localparam int SFX_LIFE_LOST = 0;
    localparam int SFX_BRICK     = 1;
    localparam int SFX_PADDLE    = 2;
    localparam int SFX_WALL      = 3;

    localparam int PERIOD_W = 17;
    localparam int DUR_W    = 8;
    localparam int ID_W     = 2;
    localparam int IDX_W    = 2;

    typedef struct packed {
        logic [PERIOD_W-1:0] half_period;
        logic [DUR_W-1:0]    duration;
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Table body; any slot not listed is an end marker (duration 0).
    function automatic note_t note_table(input logic [ID_W-1:0] id,
                                         input logic [IDX_W-1:0] idx);
        note_t n;
        n = '0;
        case ({id, idx})
            4'b00_00: n = '{half_period: 17'd45455, duration: 8'd60};
            4'b00_01: n = '{half_period: 17'd60676, duration: 8'd60};
            4'b00_10: n = '{half_period: 17'd90909, duration: 8'd120};
            4'b01_00: n = '{half_period: 17'd30337, duration: 8'd15};
            4'b01_01: n = '{half_period: 17'd22727, duration: 8'd15};
            4'b10_00: n = '{half_period: 17'd45455, duration: 8'd20};
            4'b11_00: n = '{half_period: 17'd22727, duration: 8'd10};
            default:  n = '0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_note_rom.sv
`default_nettype none
// ============================================================================
// Module   : sfx_note_rom
// Purpose  : Combinational {effect ID, note index} -> note lookup.
// Revision : 1.0 - initial release
// ============================================================================
module sfx_note_rom
    import sfx_pkg::*;
(
    input  logic [ID_W-1:0]  i_id,
    input  logic [IDX_W-1:0] i_idx,
    output note_t            o_note
);

    always_comb begin
        o_note = note_table(i_id, i_idx);
    end

endmodule
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sfx_sequencer
// Purpose  : Fixed-priority scheduler that plays short note sequences on the
//            shared tone generator; outputs a half-period word (0 = silent).
// Revision : 1.0 - initial release
// ============================================================================
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV = 40000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [3:0]          REQ,
    output logic [PERIOD_W-1:0] TONE_HALF_PERIOD,
    output logic                BUSY,
    output logic [ID_W-1:0]     ACTIVE_ID
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(TICK_DIV - 1);

    state_t              r_state_q, w_state_d;
    logic [ID_W-1:0]     r_id_q,    w_id_d;
    logic [IDX_W-1:0]    r_idx_q,   w_idx_d;
    logic [PERIOD_W-1:0] r_tone_q,  w_tone_d;
    logic                r_busy_q,  w_busy_d;
    logic [PRESC_W-1:0]  r_presc_q, w_presc_d;
    logic [DUR_W-1:0]    r_cnt_q,   w_cnt_d;
    logic [DUR_W-1:0]    r_dur_q,   w_dur_d;

    note_t           w_note;
    logic            w_req_valid;
    logic [ID_W-1:0] w_req_id;
    logic            w_tick;
    logic [DUR_W-1:0] w_cnt_inc;

    sfx_note_rom u_rom (
        .i_id   (r_id_q),
        .i_idx  (r_idx_q),
        .o_note (w_note)
    );

    // Lowest set bit wins; lower-priority bits in the same cycle are dropped.
    always_comb begin
        w_req_valid = |REQ;
        if (REQ[0])      w_req_id = 2'd0;
        else if (REQ[1]) w_req_id = 2'd1;
        else if (REQ[2]) w_req_id = 2'd2;
        else             w_req_id = 2'd3;
    end

    assign w_tick    = (r_presc_q == c_presc_last);
    assign w_cnt_inc = r_cnt_q + 8'd1;

    always_comb begin
        w_state_d = r_state_q;
        w_id_d    = r_id_q;
        w_idx_d   = r_idx_q;
        w_tone_d  = r_tone_q;
        w_busy_d  = r_busy_q;
        w_presc_d = r_presc_q;
        w_cnt_d   = r_cnt_q;
        w_dur_d   = r_dur_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_req_valid) begin
                    w_id_d    = w_req_id;
                    w_idx_d   = '0;
                    w_busy_d  = 1'b1;
                    w_state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_note.duration == '0) begin
                    w_state_d = ST_IDLE;
                    w_busy_d  = 1'b0;
                    w_tone_d  = '0;
                    w_idx_d   = '0;
                end else begin
                    w_tone_d  = w_note.half_period;
                    w_dur_d   = w_note.duration;
                    w_presc_d = '0;
                    w_cnt_d   = '0;
                    w_state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_presc_d = w_tick ? '0 : r_presc_q + 1'b1;
                if (w_tick) begin
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == r_dur_q) begin
                        w_state_d = ST_GAP;
                        w_tone_d  = '0;
                        w_presc_d = '0;
                    end
                end
            end
            ST_GAP: begin
                w_presc_d = w_tick ? '0 : r_presc_q + 1'b1;
                if (w_tick) begin
                    if (r_idx_q == 2'd3) begin
                        w_state_d = ST_IDLE;
                        w_busy_d  = 1'b0;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d   = r_idx_q + 2'd1;
                        w_state_d = ST_LOAD;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Preempt or restart; the old tone is held through LOAD so there is no dropout.
        if (r_state_q != ST_IDLE && w_req_valid && w_req_id <= r_id_q) begin
            w_state_d = ST_LOAD;
            w_id_d    = w_req_id;
            w_idx_d   = '0;
            w_presc_d = '0;
            w_cnt_d   = '0;
            w_busy_d  = 1'b1;
            w_tone_d  = r_tone_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= ST_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_tone_q  <= '0;
            r_busy_q  <= 1'b0;
            r_presc_q <= '0;
            r_cnt_q   <= '0;
            r_dur_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_id_q    <= w_id_d;
            r_idx_q   <= w_idx_d;
            r_tone_q  <= w_tone_d;
            r_busy_q  <= w_busy_d;
            r_presc_q <= w_presc_d;
            r_cnt_q   <= w_cnt_d;
            r_dur_q   <= w_dur_d;
        end
    end

    assign TONE_HALF_PERIOD = r_tone_q;
    assign BUSY             = r_busy_q;
    assign ACTIVE_ID        = r_id_q;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfx_sequencer
// Purpose  : Directed self-checking bench for sfx_sequencer with TICK_DIV=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfx_sequencer;

    localparam int TICK_DIV = 10;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [16:0] tone;
    logic        busy;
    logic [1:0]  active_id;

    int n_checks = 0;
    int n_fail   = 0;

    sfx_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .CLK              (clk),
        .RESET            (rst),
        .REQ              (req),
        .TONE_HALF_PERIOD (tone),
        .BUSY             (busy),
        .ACTIVE_ID        (active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are observed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Drive a one-cycle pulse in the current cycle t; returns in cycle t+1.
    task automatic pulse(input logic [3:0] v);
        req = v;
        step();
        req = 4'b0000;
    endtask

    // Consecutive cycles (from the current one) with tone == v, bounded.
    task automatic run_len(input logic [16:0] v, output int n);
        n = 0;
        while (tone === v && n < 3000) begin
            n++;
            step();
        end
    endtask

    // Cycles (from the current one) until BUSY falls, bounded; tone must be 0 throughout.
    task automatic busy_tail(output int n, output int loud);
        n = 0;
        loud = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (tone !== 17'd0) loud++;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (tone !== 17'd0 || busy !== 1'b0 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: tone=%0d busy=%0b id=%0d, expected 0/0/0", tone, busy, active_id);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tone !== 17'd0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_paddle();
        int n, loud;
        pulse(4'b0100);
        n_checks++;
        if (busy !== 1'b1 || active_id !== 2'd2 || tone !== 17'd0) begin
            n_fail++;
            $display("FAIL paddle_t1: busy=%0b id=%0d tone=%0d, expected 1/2/0", busy, active_id, tone);
        end
        step();
        run_len(17'd45455, n);
        n_checks++;
        if (n != 200) begin
            n_fail++;
            $display("FAIL paddle_note_len: got %0d cycles, expected 200", n);
        end
        // 10 GAP cycles plus the end-marker LOAD cycle, then BUSY falls at t+213.
        busy_tail(n, loud);
        n_checks++;
        if (n != 11 || loud != 0) begin
            n_fail++;
            $display("FAIL paddle_tail: got %0d silent-busy cycles (%0d loud), expected 11 (0)", n, loud);
        end
    endtask

    task automatic test_brick();
        int n, loud;
        pulse(4'b0010);
        n_checks++;
        if (active_id !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL brick_id: id=%0d busy=%0b, expected 1/1", active_id, busy);
        end
        step();
        run_len(17'd30337, n);
        n_checks++;
        if (n != 150) begin
            n_fail++;
            $display("FAIL brick_note0: got %0d cycles, expected 150", n);
        end
        // GAP (10 cycles) followed by the silent LOAD cycle.
        run_len(17'd0, n);
        n_checks++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL brick_gap: got %0d silent cycles, expected 11", n);
        end
        run_len(17'd22727, n);
        n_checks++;
        if (n != 150) begin
            n_fail++;
            $display("FAIL brick_note1: got %0d cycles, expected 150", n);
        end
        busy_tail(n, loud);
        n_checks++;
        if (n != 11 || loud != 0 || active_id !== 2'd1) begin
            n_fail++;
            $display("FAIL brick_tail: n=%0d loud=%0d id=%0d, expected 11/0/1", n, loud, active_id);
        end
    endtask

    task automatic test_preempt();
        int n, loud;
        pulse(4'b1000);
        step();
        n_checks++;
        if (tone !== 17'd22727) begin
            n_fail++;
            $display("FAIL wall_start: tone=%0d, expected 22727", tone);
        end
        repeat (48) step();
        pulse(4'b0001);
        n_checks++;
        if (tone !== 17'd22727 || active_id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_t51: tone=%0d id=%0d busy=%0b, expected 22727/0/1", tone, active_id, busy);
        end
        step();
        run_len(17'd45455, n);
        n_checks++;
        if (n != 600) begin
            n_fail++;
            $display("FAIL life_note0: got %0d cycles, expected 600", n);
        end
        run_len(17'd0, n);
        n_checks++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL life_gap0: got %0d silent cycles, expected 11", n);
        end
        run_len(17'd60676, n);
        n_checks++;
        if (n != 600) begin
            n_fail++;
            $display("FAIL life_note1: got %0d cycles, expected 600", n);
        end
        run_len(17'd0, n);
        n_checks++;
        if (n != 11) begin
            n_fail++;
            $display("FAIL life_gap1: got %0d silent cycles, expected 11", n);
        end
        run_len(17'd90909, n);
        n_checks++;
        if (n != 1200) begin
            n_fail++;
            $display("FAIL life_note2: got %0d cycles, expected 1200", n);
        end
        busy_tail(n, loud);
        n_checks++;
        if (n != 11 || loud != 0 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL life_tail: n=%0d loud=%0d id=%0d, expected 11/0/0", n, loud, active_id);
        end
    endtask

    task automatic test_drop_restart();
        int n, loud;
        pulse(4'b0001);
        step();
        repeat (100) step();
        pulse(4'b0100);
        n_checks++;
        if (tone !== 17'd45455 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_paddle: tone=%0d id=%0d, expected 45455/0", tone, active_id);
        end
        repeat (199) step();
        pulse(4'b0001);
        n_checks++;
        if (tone !== 17'd45455 || active_id !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_load: tone=%0d id=%0d busy=%0b, expected 45455/0/1", tone, active_id, busy);
        end
        step();
        run_len(17'd45455, n);
        n_checks++;
        if (n != 600) begin
            n_fail++;
            $display("FAIL restart_len: got %0d cycles, expected 600", n);
        end
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            step();
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_end: busy=%0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_simultaneous_reset();
        pulse(4'b1010);
        n_checks++;
        if (active_id !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_id: id=%0d, expected 1", active_id);
        end
        step();
        n_checks++;
        if (tone !== 17'd30337) begin
            n_fail++;
            $display("FAIL simul_tone: tone=%0d, expected 30337", tone);
        end
        repeat (20) step();
        rst = 1'b1;
        req = 4'b0001;
        step();
        n_checks++;
        if (tone !== 17'd0 || busy !== 1'b0 || active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL midnote_reset: tone=%0d busy=%0b id=%0d, expected 0/0/0", tone, busy, active_id);
        end
        rst = 1'b0;
        req = 4'b0000;
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || tone !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_req_ignored: busy=%0b tone=%0d, expected 0/0", busy, tone);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_paddle();
        test_brick();
        test_preempt();
        test_drop_restart();
        test_simultaneous_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
